// File: rtl/onewire_pad_ctrl.sv
// 1-Wire bus master for one open-drain pad: bus reset/presence detect and
// LSB-first byte/bit time slots, all timed from a microsecond prescaler.
module onewire_pad_ctrl #(
  parameter int unsigned CLK_PER_US = 50,
  parameter int unsigned T_RSTL_US  = 480,
  parameter int unsigned T_PDS_US   = 70,
  parameter int unsigned T_RSTH_US  = 410,
  parameter int unsigned T_LOW1_US  = 6,
  parameter int unsigned T_LOW0_US  = 60,
  parameter int unsigned T_SAMP_US  = 15,
  parameter int unsigned T_SLOT_US  = 70
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       POUT,
  output logic       POUT_EN,
  input  logic       PIN
);

  localparam int unsigned CW = 16;
  typedef logic [CW-1:0] cnt_t;

  // Phase boundaries are "last cycle of microsecond N-1" so N us is exactly
  // N*CLK_PER_US cycles; sample points are the first cycle of microsecond N.
  localparam cnt_t PRE_LAST  = cnt_t'(CLK_PER_US - 1);
  localparam cnt_t RSTL_LAST = cnt_t'(T_RSTL_US - 1);
  localparam cnt_t RSTH_LAST = cnt_t'(T_RSTH_US - 1);
  localparam cnt_t LOW1_LAST = cnt_t'(T_LOW1_US - 1);
  localparam cnt_t LOW0_LAST = cnt_t'(T_LOW0_US - 1);
  localparam cnt_t SLOT_LAST = cnt_t'(T_SLOT_US - 1);
  localparam cnt_t PDS_US    = cnt_t'(T_PDS_US);
  localparam cnt_t SAMP_US   = cnt_t'(T_SAMP_US);

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_BYTE  = 2'd1;
  localparam logic [1:0] OP_BIT   = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    RST_LOW,
    RST_HIGH,
    SLOT,
    DONE
  } state_t;

  state_t     state;
  cnt_t       presc;
  cnt_t       us;
  logic [2:0] bit_idx;
  logic [2:0] bit_last;
  logic [7:0] wdata_q;
  logic       pin_meta;
  logic       pin_sync;

  logic us_wrap;
  logic rstl_end;
  logic rsth_end;
  logic low_end;
  logic slot_end;
  logic pds_pt;
  logic samp_pt;

  assign POUT = 1'b0;

  assign us_wrap  = (presc == PRE_LAST);
  assign rstl_end = us_wrap && (us == RSTL_LAST);
  assign rsth_end = us_wrap && (us == RSTH_LAST);
  assign low_end  = us_wrap && (us == (wdata_q[bit_idx] ? LOW1_LAST : LOW0_LAST));
  assign slot_end = us_wrap && (us == SLOT_LAST);
  assign pds_pt   = (presc == '0) && (us == PDS_US);
  assign samp_pt  = (presc == '0) && (us == SAMP_US);

  // Idle bus reads high through the pull-up.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pin_meta <= 1'b1;
      pin_sync <= 1'b1;
    end else begin
      pin_meta <= PIN;
      pin_sync <= pin_meta;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      presc     <= '0;
      us        <= '0;
      bit_idx   <= '0;
      bit_last  <= '0;
      wdata_q   <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      POUT_EN   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;

      if (state == IDLE || state == DONE) begin
        presc <= '0;
        us    <= '0;
      end else if (us_wrap) begin
        presc <= '0;
        us    <= us + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            wdata_q   <= cmd_wdata;
            bit_idx   <= '0;
            bit_last  <= (cmd_op == OP_BYTE) ? 3'd7 : 3'd0;
            rsp_data  <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            case (cmd_op)
              OP_RESET: begin
                state   <= RST_LOW;
                POUT_EN <= 1'b1;
              end
              OP_BYTE, OP_BIT: begin
                state   <= SLOT;
                POUT_EN <= 1'b1;
              end
              default: begin
                state     <= DONE;
                rsp_valid <= 1'b1;
              end
            endcase
          end
        end

        RST_LOW: begin
          if (rstl_end) begin
            state   <= RST_HIGH;
            POUT_EN <= 1'b0;
            presc   <= '0;
            us      <= '0;
          end
        end

        RST_HIGH: begin
          if (pds_pt) begin
            rsp_data <= {7'd0, ~pin_sync};
          end
          if (rsth_end) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
          end
        end

        SLOT: begin
          if (low_end) begin
            POUT_EN <= 1'b0;
          end
          if (samp_pt) begin
            rsp_data[bit_idx] <= pin_sync;
          end
          // Next slot starts back-to-back: drive low again on the same edge.
          if (slot_end) begin
            presc <= '0;
            us    <= '0;
            if (bit_idx != bit_last) begin
              bit_idx <= bit_idx + 1'b1;
              POUT_EN <= 1'b1;
            end else begin
              state     <= DONE;
              rsp_valid <= 1'b1;
            end
          end
        end

        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          POUT_EN <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onewire_pad_ctrl.sv
// Scoreboard bench for onewire_pad_ctrl at CLK_PER_US=4 with a simple
// open-drain device model on the bus.
module tb_onewire_pad_ctrl;

  localparam int unsigned CPU = 4;
  localparam int BUDGET = 10000;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [7:0] cmd_wdata = '0;
  logic       cmd_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       POUT;
  logic       POUT_EN;
  logic       PIN;
  logic       dev_pull = 1'b0;

  assign PIN = ~(POUT_EN | dev_pull);

  onewire_pad_ctrl #(.CLK_PER_US(CPU)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .POUT      (POUT),
    .POUT_EN   (POUT_EN),
    .PIN       (PIN)
  );

  initial forever #5 HCLK = ~HCLK;

  int cyc = 0;
  initial forever begin
    @(posedge HCLK);
    cyc++;
  end

  typedef struct {
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   wq[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d (0x%0h) expected=%0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Response monitor
  bit ready_due = 1'b0;
  initial forever begin
    @(negedge HCLK);
    if (HRESETn) begin
      chk("pout_tied_low", int'(POUT), 0);
      chk("busy_vs_ready", int'(busy), int'(!cmd_ready));
      if (ready_due) begin
        chk("ready_after_rsp", int'(cmd_ready), 1);
        chk("released_after_rsp", int'(POUT_EN), 0);
      end
      ready_due = 1'b0;
      if (rsp_valid) begin
        chk("rsp_expected", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_data", int'(rsp_data), int'(e.data));
          chk("rsp_latency", cyc, e.at);
          ready_due = 1'b1;
        end
      end
    end else begin
      ready_due = 1'b0;
    end
  end

  // Low-pulse width and slot period monitor
  int run = 0;
  int last_rise = 0;
  bit prev_en = 1'b0;
  bit have_rise = 1'b0;
  bit rsp_since = 1'b0;
  initial forever begin
    @(negedge HCLK);
    if (!HRESETn) begin
      run = 0;
      prev_en = 1'b0;
      have_rise = 1'b0;
    end else begin
      if (POUT_EN) begin
        if (!prev_en) begin
          if (have_rise && !rsp_since) chk("slot_period", cyc - last_rise, 280);
          last_rise = cyc;
          have_rise = 1'b1;
          rsp_since = 1'b0;
        end
        run++;
      end else if (prev_en) begin
        chk("pulse_expected", int'(wq.size() != 0), 1);
        if (wq.size() != 0) chk("pulse_width", run, wq.pop_front());
        run = 0;
      end
      prev_en = POUT_EN;
      if (rsp_valid) rsp_since = 1'b1;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] wd, input logic [7:0] exp_d,
                       input int lat, input bit keep, input bit want_rsp, output int acc);
    int n;
    exp_t e;
    @(negedge HCLK);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_wdata = wd;
    n = 0;
    while (!cmd_ready && n < BUDGET) begin
      @(negedge HCLK);
      n++;
    end
    acc = cyc;
    chk("accept_in_budget", int'(cmd_ready), 1);
    if (cmd_ready && want_rsp) begin
      e.data = exp_d;
      e.at   = cyc + lat;
      sb.push_back(e);
    end
    @(posedge HCLK);
    #1;
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_pout(input logic want, input int budget, output bit ok);
    logic prev;
    prev = POUT_EN;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge HCLK);
      if (POUT_EN == want && prev != want) begin
        ok = 1'b1;
        break;
      end
      prev = POUT_EN;
    end
  endtask

  task automatic dev_presence();
    bit ok;
    wait_pout(1'b0, 3000, ok);
    chk("dev_saw_release", int'(ok), 1);
    if (ok) begin
      repeat (30 * CPU) @(posedge HCLK);
      dev_pull = 1'b1;
      repeat (120 * CPU) @(posedge HCLK);
      dev_pull = 1'b0;
    end
  endtask

  // Pull the bus low from 6us to 45us into each masked slot.
  task automatic dev_slots(input logic [7:0] mask);
    bit ok;
    for (int b = 0; b < 8; b++) begin
      wait_pout(1'b1, 600, ok);
      chk("dev_saw_slot", int'(ok), 1);
      if (!ok) break;
      if (mask[b]) begin
        repeat (6 * CPU) @(posedge HCLK);
        dev_pull = 1'b1;
        repeat (39 * CPU) @(posedge HCLK);
        dev_pull = 1'b0;
      end
    end
  endtask

  task automatic drain();
    for (int n = 0; n < BUDGET; n++) begin
      if (sb.size() == 0 && wq.size() == 0 && cmd_ready) break;
      @(negedge HCLK);
    end
    chk("drain_pending", sb.size() + wq.size(), 0);
    repeat (3) @(negedge HCLK);
  endtask

  int acc1, acc2;

  initial begin
    repeat (3) @(negedge HCLK);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_pout_en", int'(POUT_EN), 0);
    chk("rst_pout", int'(POUT), 0);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);

    // Reset op with a device answering presence
    wq.push_back(1920);
    fork
      issue(2'd0, 8'h00, 8'h01, 3561, 1'b0, 1'b1, acc1);
      dev_presence();
    join
    drain();

    // Reset op, empty bus
    wq.push_back(1920);
    issue(2'd0, 8'h00, 8'h00, 3561, 1'b0, 1'b1, acc1);
    drain();

    // Byte write 0xA5, no device
    foreach (wq[i]) wq.delete(i);
    wq.push_back(24);  wq.push_back(240); wq.push_back(24);  wq.push_back(240);
    wq.push_back(240); wq.push_back(24);  wq.push_back(240); wq.push_back(24);
    issue(2'd1, 8'hA5, 8'hA5, 2241, 1'b0, 1'b1, acc1);
    drain();

    // Byte read with the device answering 0 in bits 0,1,6,7
    for (int i = 0; i < 8; i++) wq.push_back(24);
    fork
      issue(2'd1, 8'hFF, 8'h3C, 2241, 1'b0, 1'b1, acc1);
      dev_slots(8'hC3);
    join
    drain();

    // Back-to-back bit ops with cmd_valid held high
    wq.push_back(24);
    issue(2'd2, 8'h01, 8'h01, 281, 1'b1, 1'b1, acc1);
    wq.push_back(240);
    issue(2'd2, 8'h00, 8'h00, 281, 1'b0, 1'b1, acc2);
    chk("held_second_accept", acc2, acc1 + 282);
    drain();

    // Reset in the middle of a write-0 low phase
    issue(2'd2, 8'h00, 8'h00, 281, 1'b0, 1'b0, acc1);
    repeat (100) @(negedge HCLK);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("midrst_pout_en", int'(POUT_EN), 0);
    chk("midrst_rsp_valid", int'(rsp_valid), 0);
    chk("midrst_cmd_ready", int'(cmd_ready), 1);
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (400) @(negedge HCLK);
    chk("midrst_no_rsp", sb.size(), 0);

    // Normal operation after the aborted command
    wq.push_back(24);
    issue(2'd2, 8'h01, 8'h01, 281, 1'b0, 1'b1, acc1);
    drain();

    // Reserved op completes on the next cycle with zero data
    issue(2'd3, 8'hAB, 8'h00, 1, 1'b0, 1'b1, acc1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/onewire_pad_ctrl.md
Name: onewire_pad_ctrl

Overview:
- 1-Wire bus master that sequences a single open-drain I/O pad with a pull-up (pad exposes POUT / POUT_EN / PIN).
- Generates bus reset/presence, write and read time slots from a microsecond timebase.
- Presents a simple valid/ready command interface to an APB/AHB register wrapper or to the Cortex-M software via that wrapper.
- Bus is only ever driven low or released; the high level comes from the pad pull-up.

Parameters:
- CLK_PER_US, 50, HCLK cycles per microsecond (>=2)
- T_RSTL_US, 480, reset low time
- T_PDS_US, 70, presence sample point after release
- T_RSTH_US, 410, total high time after release in reset op (>T_PDS_US)
- T_LOW1_US, 6, low time for write-1 / read slot
- T_LOW0_US, 60, low time for write-0 slot
- T_SAMP_US, 15, sample point from slot start (>T_LOW1_US, <T_LOW0_US)
- T_SLOT_US, 70, total slot length incl. recovery (>T_LOW0_US)

Ports:
- HCLK, input, 1, clock
- HRESETn, input, 1, async active-low reset
- cmd_valid, input, 1, command request
- cmd_ready, output, 1, controller idle, command accepted when valid&ready
- cmd_op, input, 2, 0=bus reset, 1=byte transfer, 2=bit transfer, 3=reserved (accepted, completes next cycle, rsp_data=0)
- cmd_wdata, input, 8, byte to send LSB first (bit op uses [0])
- rsp_valid, output, 1, one-cycle completion pulse
- rsp_data, output, 8, reset op: [0]=presence; byte op: sampled bits; bit op: [0]=sampled bit; other bits 0
- busy, output, 1, equals ~cmd_ready
- POUT, output, 1, pad data, tied 0
- POUT_EN, output, 1, pad drive enable, 1 = pull bus low
- PIN, input, 1, pad input (asynchronous)

Behaviour:
- Reset (async, HRESETn=0): POUT_EN=0 immediately (bus released), cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0, state IDLE, all counters 0. POUT constant 0.
- PIN passes through a 2-flop synchronizer; all sampling uses the synchronized value.
- Timebase: prescaler counts 0..CLK_PER_US-1 and runs only outside IDLE. A us counter increments on prescaler wrap and is cleared at each phase start. Phase durations are exact: N us = N*CLK_PER_US cycles.
- States: IDLE, RST_LOW, RST_HIGH, SLOT, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch op/wdata, set bit index=0, bit count (8 byte / 1 bit), then transition on the same edge. cmd_valid is ignored while not IDLE.
- RST_LOW:
  - POUT_EN=1 from the first cycle after acceptance for T_RSTL_US.
  - Then go to RST_HIGH with POUT_EN=0.
- RST_HIGH:
  - Presence = ~PIN_sync, sampled in the cycle where elapsed == T_PDS_US*CLK_PER_US.
  - Move to DONE when elapsed reaches T_RSTH_US.
- SLOT:
  - POUT_EN=1 from slot start for T_LOW1_US if the current bit is 1, else T_LOW0_US; then POUT_EN=0.
  - Sample PIN_sync into rsp_data[bit index] at elapsed == T_SAMP_US.
  - At T_SLOT_US: if more bits remain, increment the index and start the next slot back-to-back (POUT_EN=1 next cycle); else go to DONE.
  - A read is a transfer with wdata=8'hFF.
- DONE: one cycle. rsp_valid=1, rsp_data valid and held until the next acceptance. Return to IDLE, so cmd_ready=1 the following cycle.
- Latency, from acceptance edge to the rsp_valid cycle:
  - reset op: (T_RSTL_US+T_RSTH_US)*CLK_PER_US+1 cycles
  - byte op: 8*T_SLOT_US*CLK_PER_US+1 cycles
  - bit op: T_SLOT_US*CLK_PER_US+1 cycles
- Bit order: LSB first on the wire and in rsp_data.
- Bus held low by an external device past the slot end: no timeout; sampling is unaffected.
- Reset mid-operation releases the bus within the same cycle (async clear of the POUT_EN flop) and discards the command with no rsp_valid.

Test Plan:
- CLK_PER_US=4, reset op, device model pulls low from 30us to 150us after release -> POUT_EN high exactly 1920 cycles; rsp_valid at cycle 3561; rsp_data=8'h01.
- Same reset op, no device -> rsp_data=8'h00; bus released; cmd_ready=1 the cycle after rsp_valid.
- Byte op wdata=8'hA5 -> POUT_EN low-pulse widths in cycles, LSB first: 24,240,24,240,240,24,240,24; slot period 280; rsp_data=8'hA5 (no device).
- Byte op wdata=8'hFF, device pulls low 6-45us in slots for bits 0,1,6,7 -> rsp_data=8'h3C.
- Two commands with cmd_valid held high -> second accepted the cycle after rsp_valid; cmd_valid ignored (cmd_ready=0) throughout the first op.
- HRESETn asserted during write-0 low phase -> POUT_EN=0 without a clock edge; no rsp_valid; after release, a new bit op completes normally.
